// File: rtl/fizzbuzz_pkg.sv
// fizzbuzz_pkg: shared types and constants for the FizzBuzz serial line
// generator.
//   - ASCII constants (CR, LF, '0') and the "Fizz"/"Buzz" byte strings
//   - FSM state enum and the line-type enum
//   - 4-bit BCD digit type
//   - str_byte(): picks byte k (0 = first character) out of a 4-char string
package fizzbuzz_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    SEND,
    NEXT,
    STOP
  } state_t;

  typedef enum logic [1:0] {
    LINE_NUM,
    LINE_FIZZ,
    LINE_BUZZ,
    LINE_FIZZBUZZ
  } line_t;

  localparam logic [7:0]  ASCII_CR   = 8'h0D;
  localparam logic [7:0]  ASCII_LF   = 8'h0A;
  localparam logic [7:0]  ASCII_ZERO = 8'h30;
  // First character sits in the most significant byte.
  localparam logic [31:0] FIZZ_STR   = 32'h46_69_7A_7A;
  localparam logic [31:0] BUZZ_STR   = 32'h42_75_7A_7A;

  function automatic logic [7:0] str_byte(input logic [31:0] s, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = s[31:24];
      2'd1:    b = s[23:16];
      2'd2:    b = s[15:8];
      default: b = s[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter, LSB first, idle high.
//   clk   in   system clock
//   rst   in   asynchronous active-low reset; forces out high at once
//   data  in   byte to send, taken when valid && ready
//   valid in   byte offered
//   ready out  high when idle or in the last cycle of a stop bit, so a
//              byte offered continuously goes out with no idle gap
//   out   out  serial line
module uart_tx #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       out
);

  localparam int              BAUD_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

  logic              active_reg;
  logic [BAUD_W-1:0] baud_cnt_reg;
  logic [3:0]        bit_cnt_reg;   // bit currently on the line: 0 start, 1..8 data, 9 stop
  logic [8:0]        shift_reg;     // remaining data bits followed by the stop bit
  logic              out_reg;
  logic              bit_end;

  assign bit_end = (baud_cnt_reg == BAUD_LAST);
  assign ready   = !active_reg || (bit_end && (bit_cnt_reg == 4'd9));
  assign out     = out_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_reg   <= 1'b0;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= 4'd0;
      shift_reg    <= '1;
      out_reg      <= 1'b1;
    end else if (valid && ready) begin
      // Start bit goes out on the next cycle; this also covers a byte
      // chained onto the final cycle of the previous stop bit.
      active_reg   <= 1'b1;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= 4'd0;
      shift_reg    <= {1'b1, data};
      out_reg      <= 1'b0;
    end else if (active_reg) begin
      if (bit_end) begin
        baud_cnt_reg <= '0;
        if (bit_cnt_reg == 4'd9) begin
          active_reg <= 1'b0;
        end else begin
          out_reg     <= shift_reg[0];
          shift_reg   <= {1'b1, shift_reg[8:1]};
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
      end else begin
        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
      end
    end
  end

endmodule

// File: rtl/fizzbuzz_uart_gen.sv
// fizzbuzz_uart_gen: counts n = 1..MAX_N and sends one CR LF terminated
// ASCII line per n over an 8N1 serial line: "Fizz", "Buzz", "FizzBuzz" or
// n in decimal without leading zeros. n is kept in BCD and divisibility is
// tracked with modulo counters, so no divider is needed.
//   clk   in   system clock
//   rst   in   asynchronous active-low reset
//   en    in   run enable, looked at only between lines
//   out   out  serial TX, idle high
//   busy  out  high from line selection until the LF stop bit has ended
//   done  out  sticky, set after the MAX_N line when WRAP = 0
module fizzbuzz_uart_gen
  import fizzbuzz_pkg::*;
#(
  parameter int BAUD_DIV = 434,
  parameter int MAX_N    = 100,
  parameter int DIGITS   = 3,
  parameter int FIZZ_DIV = 3,
  parameter int BUZZ_DIV = 5,
  parameter int WRAP     = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic out,
  output logic busy,
  output logic done
);

  localparam int LEN_MAX = (DIGITS + 2 > 10) ? DIGITS + 2 : 10;
  localparam int IDX_W   = $clog2(LEN_MAX + 1);
  localparam int M3_W    = $clog2(FIZZ_DIV + 1);
  localparam int M5_W    = $clog2(BUZZ_DIV + 1);
  localparam logic [M3_W-1:0] M3_INIT = M3_W'(1 % FIZZ_DIV);
  localparam logic [M5_W-1:0] M5_INIT = M5_W'(1 % BUZZ_DIV);
  localparam logic [M3_W-1:0] M3_LAST = M3_W'(FIZZ_DIV - 1);
  localparam logic [M5_W-1:0] M5_LAST = M5_W'(BUZZ_DIV - 1);

  state_t            state_reg, state_next;
  bcd_t              n_reg [DIGITS];
  bcd_t              n_inc [DIGITS];
  logic [DIGITS-1:0] carry;
  logic [DIGITS-1:0] digit_at_max;
  logic              at_max;
  logic [M3_W-1:0]   m3_reg;
  logic [M5_W-1:0]   m5_reg;
  line_t             line_reg, line_sel;
  logic [IDX_W-1:0]  idx_reg, len_reg, len_sel, ndig_sel, dpos;
  logic              lf_acc_reg;   // LF handed to the transmitter, waiting for its stop bit
  logic              done_reg;
  logic              tx_valid, tx_ready, hs;
  logic [7:0]        tx_data;
  bcd_t              digit_sel;

  // BCD increment with rippling carry, and per-digit compare against MAX_N.
  assign carry[0] = 1'b1;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    localparam bcd_t MAX_DIGIT = bcd_t'((MAX_N / (10 ** gi)) % 10);
    assign n_inc[gi] = carry[gi] ? ((n_reg[gi] == 4'd9) ? 4'd0 : n_reg[gi] + 4'd1)
                                 : n_reg[gi];
    assign digit_at_max[gi] = (n_reg[gi] == MAX_DIGIT);
    if (gi < DIGITS - 1) begin : g_carry
      assign carry[gi+1] = carry[gi] && (n_reg[gi] == 4'd9);
    end
  end
  assign at_max = &digit_at_max;

  // Line type and length, registered in SEL.
  always_comb begin
    ndig_sel = IDX_W'(1);
    for (int i = 1; i < DIGITS; i++) begin
      if (n_reg[i] != 4'd0) ndig_sel = IDX_W'(i + 1);
    end
    if (m3_reg == '0 && m5_reg == '0) begin
      line_sel = LINE_FIZZBUZZ;
      len_sel  = IDX_W'(10);
    end else if (m3_reg == '0) begin
      line_sel = LINE_FIZZ;
      len_sel  = IDX_W'(6);
    end else if (m5_reg == '0) begin
      line_sel = LINE_BUZZ;
      len_sel  = IDX_W'(6);
    end else begin
      line_sel = LINE_NUM;
      len_sel  = ndig_sel + IDX_W'(2);
    end
  end

  // Byte at idx_reg: line text, then CR, then LF. For numbers the first
  // text byte is the most significant non-zero digit.
  always_comb begin
    dpos      = len_reg - IDX_W'(3) - idx_reg;
    digit_sel = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dpos == IDX_W'(i)) digit_sel = n_reg[i];
    end
    tx_data = ASCII_LF;
    if (idx_reg == len_reg - IDX_W'(1)) begin
      tx_data = ASCII_LF;
    end else if (idx_reg == len_reg - IDX_W'(2)) begin
      tx_data = ASCII_CR;
    end else begin
      case (line_reg)
        LINE_FIZZ:     tx_data = str_byte(FIZZ_STR, idx_reg[1:0]);
        LINE_BUZZ:     tx_data = str_byte(BUZZ_STR, idx_reg[1:0]);
        LINE_FIZZBUZZ: tx_data = (idx_reg < IDX_W'(4)) ? str_byte(FIZZ_STR, idx_reg[1:0])
                                                       : str_byte(BUZZ_STR, idx_reg[1:0]);
        default:       tx_data = ASCII_ZERO | {4'h0, digit_sel};
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // FSM next state and outputs.
  always_comb begin
    state_next = state_reg;
    tx_valid   = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: if (en && !done_reg) state_next = SEL;
      SEL: begin
        busy       = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        busy     = 1'b1;
        tx_valid = !lf_acc_reg;
        // ready after the LF was taken marks the last cycle of its stop bit.
        if (lf_acc_reg && tx_ready) state_next = NEXT;
      end
      NEXT: state_next = (at_max && WRAP == 0) ? STOP : IDLE;
      STOP: state_next = STOP;
      default: state_next = IDLE;
    endcase
  end

  assign hs   = tx_valid && tx_ready;
  assign done = done_reg;

  // Datapath: counter, modulo trackers, byte index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DIGITS; i++) n_reg[i] <= (i == 0) ? 4'd1 : 4'd0;
      m3_reg     <= M3_INIT;
      m5_reg     <= M5_INIT;
      line_reg   <= LINE_NUM;
      len_reg    <= IDX_W'(3);
      idx_reg    <= '0;
      lf_acc_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        SEL: begin
          line_reg   <= line_sel;
          len_reg    <= len_sel;
          idx_reg    <= '0;
          lf_acc_reg <= 1'b0;
        end
        SEND: begin
          if (hs) begin
            if (idx_reg == len_reg - IDX_W'(1)) lf_acc_reg <= 1'b1;
            else                                idx_reg    <= idx_reg + IDX_W'(1);
          end
        end
        NEXT: begin
          if (at_max) begin
            if (WRAP != 0) begin
              for (int i = 0; i < DIGITS; i++) n_reg[i] <= (i == 0) ? 4'd1 : 4'd0;
              m3_reg <= M3_INIT;
              m5_reg <= M5_INIT;
            end else begin
              done_reg <= 1'b1;
            end
          end else begin
            for (int i = 0; i < DIGITS; i++) n_reg[i] <= n_inc[i];
            m3_reg <= (m3_reg == M3_LAST) ? '0 : m3_reg + M3_W'(1);
            m5_reg <= (m5_reg == M5_LAST) ? '0 : m5_reg + M5_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .data (tx_data),
    .valid(tx_valid),
    .ready(tx_ready),
    .out  (out)
  );

endmodule
